// File: rtl/h14tx_pkg.sv
// Shared types, constants and the BCH step function for the HDMI 1.4 TX data-island path.
package h14tx_pkg;

    // One TERC4 input nibble.
    typedef logic [3:0] data_t;

    // Current sync levels. h lands on ch0[0] and v on ch0[1].
    typedef struct packed {
        logic v;
        logic h;
    } sync_timings_t;

    // Data-island packet: 24-bit header plus four 56-bit subpackets.
    typedef struct packed {
        logic [23:0]      header;
        logic [3:0][55:0] sub;
    } packet_t;

    typedef logic [7:0] ecc_t;

    typedef enum logic [0:0] {
        StIdle,
        StEmit
    } enc_state_e;

    localparam int DiPacketCycles = 32;
    localparam int HeaderBits     = 24;
    // Cycles spent on subpacket payload; the remaining cycles carry the ECC.
    localparam int SubDataCycles  = 28;
    localparam logic [7:0] BchPoly = 8'h83;

    // One serial step of the G(x)=1+x^6+x^7+x^8 LFSR, data LSB first.
    function automatic ecc_t bch_step(input ecc_t e, input logic b);
        logic fb;
        fb = e[0] ^ b;
        return (e >> 1) ^ (fb ? BchPoly : 8'h00);
    endfunction

endpackage

// File: rtl/h14tx_bch_ecc.sv
// Serial BCH ECC generator: absorbs BITS_PER_CYCLE data bits per enabled cycle,
// then shifts the frozen parity out LSB first, BITS_PER_CYCLE bits per cycle.
module h14tx_bch_ecc
    import h14tx_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      en,
    input  logic [BITS_PER_CYCLE-1:0] d,
    input  logic                      shift,
    output logic [BITS_PER_CYCLE-1:0] ecc_bits
);

    ecc_t e_q, e_d, stepped;

    // Apply the serial step once per input bit, lowest bit first.
    always_comb begin
        stepped = e_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            stepped = bch_step(stepped, d[i]);
        end
    end

    // Clear wins over absorb and shift so a back-to-back island starts clean.
    always_comb begin
        e_d = e_q;
        if (clear) begin
            e_d = '0;
        end else if (en) begin
            e_d = stepped;
        end else if (shift) begin
            e_d = e_q >> BITS_PER_CYCLE;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    assign ecc_bits = e_q[BITS_PER_CYCLE-1:0];

endmodule

// File: rtl/h14tx_packet_encoder.sv
// Data-island packet encoder: serialises one packet into 32 cycles of TERC4 nibbles on
// channels 0-2 with on-the-fly BCH ECC.
// Optional feature macro: H14TX_NULL_PACKET_EN (emit a null packet when start finds no packet).
module h14tx_packet_encoder
    import h14tx_pkg::*;
#(
    parameter int unsigned SYNC_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pkt_valid,
    output logic          pkt_ready,
    input  packet_t       pkt,
    input  sync_timings_t sync,
    output logic          di_valid,
    output data_t [2:0]   di_data,
    output logic          underflow
);

    enc_state_e    state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    packet_t       pkt_q, pkt_d;
    logic          underflow_q, underflow_d;
    logic          ecc_clear;
    logic          emit;
    logic          last;
    logic          take;
    logic          hdr_phase;
    logic          sub_phase;
    sync_timings_t sync_cur;

    logic [31:0]      hdr_word;
    logic [0:0]       hdr_d;
    logic [0:0]       hdr_ecc;
    logic [3:0][1:0]  sub_d;
    logic [3:0][1:0]  sub_ecc;

    assign emit      = (state_q == StEmit);
    assign last      = emit && (cnt_q == 5'(DiPacketCycles - 1));
    // A start in the final emission cycle chains the next island with no bubble.
    assign take      = start && ((state_q == StIdle) || last);
    assign hdr_phase = (cnt_q < 5'(HeaderBits));
    assign sub_phase = (cnt_q < 5'(SubDataCycles));

    // Next-state, packet latch, ECC clear and handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pkt_d       = pkt_q;
        underflow_d = underflow_q;
        pkt_ready   = 1'b0;
        ecc_clear   = 1'b0;

        unique case (state_q)
            StIdle: ;
            StEmit: begin
                cnt_d = cnt_q + 5'd1;
                if (last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (take) begin
            if (pkt_valid) begin
                pkt_d     = pkt;
                pkt_ready = !rst;
                ecc_clear = 1'b1;
                state_d   = StEmit;
                cnt_d     = '0;
            end else begin
                underflow_d = 1'b1;
`ifdef H14TX_NULL_PACKET_EN
                pkt_d     = '0;
                ecc_clear = 1'b1;
                state_d   = StEmit;
                cnt_d     = '0;
`else
                state_d   = StIdle;
                cnt_d     = '0;
`endif
            end
        end
    end

    // FSM, counter, packet and sticky underflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pkt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pkt_q       <= pkt_d;
            underflow_q <= underflow_d;
        end
    end

    assign underflow = underflow_q;

    // Sync path: registered to line up with the data path, or passed straight through.
    if (SYNC_REG != 0) begin : g_sync_reg
        sync_timings_t sync_q;

        // One-cycle sync delay register.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync;
            end
        end

        assign sync_cur = sync_q;
    end else begin : g_sync_comb
        assign sync_cur = sync;
    end

    // Header: one bit per cycle for the first 24 cycles, then 8 parity bits.
    assign hdr_word = {8'h00, pkt_q.header};
    assign hdr_d    = hdr_word[cnt_q];

    h14tx_bch_ecc #(
        .BITS_PER_CYCLE(1)
    ) u_hdr_ecc (
        .clk      (clk),
        .rst      (rst),
        .clear    (ecc_clear),
        .en       (emit && hdr_phase),
        .d        (hdr_d),
        .shift    (emit && !hdr_phase),
        .ecc_bits (hdr_ecc)
    );

    // Subpackets: two bits per cycle for 28 cycles, then 8 parity bits over 4 cycles.
    for (genvar k = 0; k < 4; k++) begin : g_sub_ecc
        logic [63:0] sub_word;

        assign sub_word = {8'h00, pkt_q.sub[k]};
        assign sub_d[k] = sub_word[{cnt_q, 1'b0} +: 2];

        h14tx_bch_ecc #(
            .BITS_PER_CYCLE(2)
        ) u_sub_ecc (
            .clk      (clk),
            .rst      (rst),
            .clear    (ecc_clear),
            .en       (emit && sub_phase),
            .d        (sub_d[k]),
            .shift    (emit && !sub_phase),
            .ecc_bits (sub_ecc[k])
        );
    end

    // Nibble assembly; everything reads zero outside an island.
    always_comb begin
        di_valid = 1'b0;
        di_data  = '0;
        if (emit) begin
            di_valid      = 1'b1;
            di_data[0][0] = sync_cur.h;
            di_data[0][1] = sync_cur.v;
            di_data[0][2] = hdr_phase ? hdr_d[0] : hdr_ecc[0];
            di_data[0][3] = (cnt_q != 5'd0);
            for (int k = 0; k < 4; k++) begin
                di_data[1][k] = sub_phase ? sub_d[k][0] : sub_ecc[k][0];
                di_data[2][k] = sub_phase ? sub_d[k][1] : sub_ecc[k][1];
            end
        end
    end

    // The scheduler never restarts an island before its last cycle.
    start_spacing_a : assert property (@(posedge clk) disable iff (rst)
        !(start && emit && !last));

endmodule

// File: tb/tb_h14tx_packet_encoder.sv
// Directed bench for h14tx_packet_encoder (default SYNC_REG=1).
module tb_h14tx_packet_encoder;
    import h14tx_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          pkt_valid;
    logic          pkt_ready;
    packet_t       pkt;
    sync_timings_t sync;
    logic          di_valid;
    data_t [2:0]   di_data;
    logic          underflow;

    int n_cmp = 0;
    int n_err = 0;

    h14tx_packet_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt       (pkt),
        .sync      (sync),
        .di_valid  (di_valid),
        .di_data   (di_data),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic packet_t rand_pkt();
        packet_t p;
        p.header = 24'($urandom);
        for (int k = 0; k < 4; k++) p.sub[k] = {24'($urandom), $urandom};
        return p;
    endfunction

    // Expected {ch2, ch1, ch0} for emission cycle i, straight from the packet layout.
    function automatic logic [11:0] model(input packet_t p, input int i, input sync_timings_t s);
        ecc_t       he;
        ecc_t       se [4];
        logic [3:0] c0, c1, c2;
        he = '0;
        for (int j = 0; j < 24; j++) he = bch_step(he, p.header[j]);
        for (int k = 0; k < 4; k++) begin
            se[k] = '0;
            for (int j = 0; j < 56; j++) se[k] = bch_step(se[k], p.sub[k][j]);
        end
        c0[0] = s.h;
        c0[1] = s.v;
        c0[2] = (i < 24) ? p.header[i] : he[i-24];
        c0[3] = (i != 0);
        for (int k = 0; k < 4; k++) begin
            if (i < 28) begin
                c1[k] = p.sub[k][2*i];
                c2[k] = p.sub[k][2*i+1];
            end else begin
                c1[k] = se[k][2*(i-28)];
                c2[k] = se[k][2*(i-28)+1];
            end
        end
        return {c2, c1, c0};
    endfunction

    // Runs n islands back to back; the first uses 'first', later ones random when rnd.
    // Captures the first island's header ECC bits and sub[2] ECC bits as observed.
    task automatic run_islands(input int n, input packet_t first, input bit rnd, input string tag,
                               output logic [7:0] hdr_obs, output logic [7:0] sub2_obs);
        packet_t       cur, nxt;
        sync_timings_t prev;
        int            readies;
        cur = first;
        nxt = first;
        readies = 0;
        hdr_obs = '0;
        sub2_obs = '0;
        start = 1'b1;
        pkt_valid = 1'b1;
        pkt = cur;
        sync = sync_timings_t'(2'($urandom));
        #1;
        check($sformatf("%s_ready_at_start", tag), 32'(pkt_ready), 32'd1);
        if (pkt_ready) readies++;
        prev = sync;
        tick();
        for (int n_i = 0; n_i < n; n_i++) begin
            for (int i = 0; i < 32; i++) begin
                if (i == 31 && n_i < n - 1) begin
                    nxt = rnd ? rand_pkt() : first;
                    start = 1'b1;
                    pkt_valid = 1'b1;
                    pkt = nxt;
                end else begin
                    start = 1'b0;
                    pkt_valid = 1'b0;
                    pkt = rand_pkt();
                end
                sync = sync_timings_t'(2'($urandom));
                #1;
                check($sformatf("%s_valid_i%0d_c%0d", tag, n_i, i), 32'(di_valid), 32'd1);
                check($sformatf("%s_data_i%0d_c%0d", tag, n_i, i), 32'(di_data),
                      32'(model(cur, i, prev)));
                check($sformatf("%s_ready_i%0d_c%0d", tag, n_i, i), 32'(pkt_ready),
                      32'(start));
                if (pkt_ready) readies++;
                if (n_i == 0 && i >= 24) hdr_obs[i-24] = di_data[0][2];
                if (n_i == 0 && i >= 28) begin
                    sub2_obs[2*(i-28)]   = di_data[1][2];
                    sub2_obs[2*(i-28)+1] = di_data[2][2];
                end
                prev = sync;
                tick();
            end
            cur = nxt;
        end
        start = 1'b0;
        pkt_valid = 1'b0;
        #1;
        check($sformatf("%s_valid_after", tag), 32'(di_valid), 32'd0);
        check($sformatf("%s_ready_count", tag), 32'(readies), 32'(n));
    endtask

    initial begin
        packet_t       p;
        logic [7:0]    hdr_obs, sub2_obs;
        ecc_t          gold;
        sync_timings_t prev;

        // Reset with start/pkt_valid held high: handshake must stay quiet.
        rst = 1'b1;
        start = 1'b1;
        pkt_valid = 1'b1;
        pkt = rand_pkt();
        sync = '0;
        tick();
        tick();
        tick();
        check("rst_pkt_ready", 32'(pkt_ready), 32'd0);
        check("rst_di_valid", 32'(di_valid), 32'd0);
        check("rst_di_data", 32'(di_data), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        pkt_valid = 1'b0;
        tick();
        check("idle_di_valid", 32'(di_valid), 32'd0);

        // Header 24'h000001, subpackets zero: header parity worked by hand is 8'h4A.
        p = '0;
        p.header = 24'h000001;
        run_islands(1, p, 1'b0, "hdr1", hdr_obs, sub2_obs);
        check("hdr1_ecc_byte", 32'(hdr_obs), 32'h4A);
        check("hdr1_sub2_ecc", 32'(sub2_obs), 32'h00);
        tick();

        // sub[2] = 56'h3.
        p = '0;
        p.sub[2] = 56'h3;
        run_islands(1, p, 1'b0, "sub2", hdr_obs, sub2_obs);
        gold = '0;
        for (int j = 0; j < 56; j++) gold = bch_step(gold, p.sub[2][j]);
        check("sub2_ecc_byte", 32'(sub2_obs), 32'(gold));
        check("sub2_hdr_ecc", 32'(hdr_obs), 32'h00);
        tick();

        // Reset at cycle 10 of an island, then a fresh island.
        p = rand_pkt();
        start = 1'b1;
        pkt_valid = 1'b1;
        pkt = p;
        sync = sync_timings_t'(2'($urandom));
        prev = sync;
        tick();
        start = 1'b0;
        pkt_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            sync = sync_timings_t'(2'($urandom));
            #1;
            check($sformatf("abort_data_c%0d", i), 32'(di_data), 32'(model(p, i, prev)));
            if (i == 10) rst = 1'b1;
            prev = sync;
            tick();
        end
        rst = 1'b0;
        #1;
        check("abort_valid", 32'(di_valid), 32'd0);
        check("abort_data", 32'(di_data), 32'd0);
        check("abort_ready", 32'(pkt_ready), 32'd0);
        run_islands(1, rand_pkt(), 1'b0, "after_abort", hdr_obs, sub2_obs);
        tick();

        // 1000 random islands back to back.
        run_islands(1000, rand_pkt(), 1'b1, "b2b", hdr_obs, sub2_obs);
        check("b2b_underflow", 32'(underflow), 32'd0);
        tick();

        // start with no packet.
        start = 1'b1;
        pkt_valid = 1'b0;
        sync = sync_timings_t'(2'($urandom));
        #1;
        check("nopkt_ready", 32'(pkt_ready), 32'd0);
        prev = sync;
        tick();
        start = 1'b0;
`ifdef H14TX_NULL_PACKET_EN
        for (int i = 0; i < 32; i++) begin
            sync = sync_timings_t'(2'($urandom));
            #1;
            check($sformatf("null_valid_c%0d", i), 32'(di_valid), 32'd1);
            check($sformatf("null_data_c%0d", i), 32'(di_data), 32'(model('0, i, prev)));
            check($sformatf("null_underflow_c%0d", i), 32'(underflow), 32'd1);
            prev = sync;
            tick();
        end
        check("null_valid_after", 32'(di_valid), 32'd0);
`else
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("nopkt_valid_c%0d", i), 32'(di_valid), 32'd0);
            check($sformatf("nopkt_underflow_c%0d", i), 32'(underflow), 32'd1);
            tick();
        end
`endif

        // Underflow is sticky until reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("underflow_cleared", 32'(underflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/h14tx_packet_encoder.md
# h14tx_packet_encoder

Data-island packet encoder for the HDMI 1.4 transmitter. Accepts one `packet_t` (24-bit header plus four 56-bit subpackets) per data-island slot and serialises it over 32 pixel-clock cycles into the 4-bit `data_t` nibbles of channels 0–2. The two BCH ECC bytes are computed on the fly. Sits between the packet sources (infoframe/audio muxes) and the TERC4 channel encoders. The period scheduler drives it, asserting `start` at the first `DataIslandActive` cycle.

## Interface
- `SYNC_REG`, default 1: 1 = register `hv` sync bits into channel 0 alongside data; 0 = pass through combinationally.
- `clk` in 1: pixel clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse from the scheduler; begins a 32-cycle island packet.
- `pkt_valid` in 1: `pkt` holds a packet.
- `pkt_ready` out 1: one-cycle pulse; `pkt` is consumed.
- `pkt` in `packet_t`: header and `sub[3:0]`.
- `sync` in `sync_timings_t`: current h/v sync levels.
- `di_valid` out 1: high for exactly the 32 emission cycles.
- `di_data` out `data_t [2:0]`: TERC4 input nibble per channel.
- `underflow` out 1: sticky; set when `start` arrives with no packet.

## Operation
- FSM states: IDLE, EMIT. IDLE→EMIT on `start`. EMIT→IDLE when the cycle counter (5-bit) reaches 31.
- On `start` in IDLE with `pkt_valid`:
  - Latch `pkt`.
  - Pulse `pkt_ready`.
  - Clear both ECC LFSRs.
- Cycle i (0..31) of EMIT:
  - ch0[0] = sync.h, ch0[1] = sync.v.
  - ch0[2] = header bit i for i<24, header ECC bit (i-24) for i≥24.
  - ch0[3] = 0 when i==0, else 1.
  - For each subpacket k: ch1[k] = sub[k] bit 2i, ch2[k] = sub[k] bit 2i+1 for i<28. For i≥28, ECC bits 2(i-28) and 2(i-28)+1.
- ECC is BCH(32,24) and BCH(64,56), G(x)=1+x^6+x^7+x^8, serial LFSR, LSB first.
  - Per data bit b: fb = e[0]^b; e = (e>>1) ^ (fb ? 8'h83 : 0).
  - The header LFSR steps once per cycle for i<24.
  - Each subpacket LFSR steps twice per cycle (bit 2i, then 2i+1) for i<28.
  - ECC bits shift out of the frozen LFSR.
- `start` while in EMIT: ignored. Raise a sim assertion; the scheduler guarantees ≥32-cycle spacing.
- `pkt_valid` low at `start`: behaviour depends on the macro (see Configuration).
- `underflow` clears only on `rst`.

## Timing
- `start` at cycle t → `di_valid` and the first nibble at t+1. The last nibble is at t+32, and `di_valid` is low at t+33.
- Back-to-back islands: `start` at t+32 gives continuous emission with no bubble. Counter wraps 31→0 and the FSM stays in EMIT.
- `pkt_ready` is asserted in cycle t, the same cycle as `start`.
- Reset values: `di_valid`=0, `di_data`=0, `pkt_ready`=0, `underflow`=0, FSM=IDLE, counter=0, LFSRs=0.
- `rst` mid-packet aborts immediately. The next cycle shows reset values, and the partial packet is lost (the upstream packet was already consumed).
- With `SYNC_REG`=1, sync bits carry 1-cycle latency, matching the data path. With `SYNC_REG`=0 they carry 0 cycles.

## Configuration
- `H14TX_NULL_PACKET_EN` defined:
  - `start` without `pkt_valid` emits a null packet (header 24'h000000, all subpackets zero, all ECC zero) with full 32-cycle timing.
  - `underflow` is still set.
- Undefined: `start` without `pkt_valid` does not enter EMIT. `di_valid` stays 0 and `underflow` is set.

## Structure
- Add to `h14tx_pkg`:
  - `localparam int DiPacketCycles = 32`
  - `localparam logic [7:0] BchPoly = 8'h83`
  - `typedef logic [7:0] ecc_t`
  - a `function bch_step(ecc_t, logic)` for reuse by the bench model.
- One sub-module, `h14tx_bch_ecc`:
  - Parameter `BITS_PER_CYCLE` (1 or 2).
  - Ports: `clk`, `rst`, `clear`, `en`, `d`, `shift`, `ecc_bit(s)`.
  - Instantiated once for the header and four times for the subpackets.

## Test plan
- Null packet (macro on, `pkt_valid`=0, `start`): 32 cycles with `di_valid`=1. ch1=ch2=0, ch0[2]=0, ch0[3]=0 then 1, `underflow`=1.
- Header 24'h000001, subs zero: ch0[2]=1 at cycle 0 and 0 for cycles 1–23. Cycles 24–31 match the `bch_step` golden ECC; ch1/ch2 ECC=0.
- sub[2]=56'h3 (bits 0,1): ch1[2]=1 and ch2[2]=1 at cycle 0, 0 through cycle 27. Cycles 28–31 match the golden 64-bit ECC.
- Random packets, sync toggling, 1000 islands back-to-back at 32-cycle spacing: no gap in `di_valid`, all bits match the model, `pkt_ready` once per island.
- `rst` at cycle 10 of an island: `di_valid`=0 next cycle. A fresh `start` gives a correct packet.
- Macro off, `start` with `pkt_valid`=0: `di_valid` stays 0, `underflow`=1, `pkt_ready`=0.
